// File: rtl/div_sequencer.sv
// div_sequencer: control FSM sequencing a DW-iteration shift-subtract datapath for signed division.
// Optional abort input (i_abort) is enabled by defining DIV_SEQ_ABORT_EN.
module div_sequencer #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef DIV_SEQ_ABORT_EN
    input  logic          i_abort,
`endif
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [DW-1:0] i_divisor,
    input  logic [DW-1:0] i_dp_quotient,
    input  logic [DW-1:0] i_dp_remainder,
    output logic          o_dp_init,
    output logic          o_dp_enable,
    output logic [DW-1:0] o_dp_dividend,
    output logic [DW-1:0] o_dp_divisor,
    output logic          o_ready,
    output logic          o_done,
    output logic [DW-1:0] o_quotient,
    output logic [DW-1:0] o_remainder,
    output logic          o_div_by_zero,
    output logic          o_overflow
);

    localparam logic [DW-1:0] ONE     = DW'(1);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic          neg_quot_q, neg_quot_d;
    logic          neg_rem_q, neg_rem_d;
    logic          ovf_case_q, ovf_case_d;
    logic          init_q, init_d;
    logic          enable_q, enable_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic          abort_c;
    logic [DW-1:0] dividend_mag_c;
    logic [DW-1:0] divisor_mag_c;

`ifdef DIV_SEQ_ABORT_EN
    assign abort_c = i_abort;
`else
    assign abort_c = 1'b0;
`endif

    // Two's-complement magnitudes; MIN_NEG maps onto itself, which is its correct unsigned magnitude.
    assign dividend_mag_c = i_dividend[DW-1] ? (~i_dividend + ONE) : i_dividend;
    assign divisor_mag_c  = i_divisor[DW-1]  ? (~i_divisor + ONE)  : i_divisor;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ovf_case_d = ovf_case_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    dvd_d      = dividend_mag_c;
                    dvs_d      = divisor_mag_c;
                    neg_quot_d = i_dividend[DW-1] ^ i_divisor[DW-1];
                    neg_rem_d  = i_dividend[DW-1];
                    ovf_case_d = (i_dividend == MIN_NEG) && (i_divisor == '1);
                    quot_d     = '0;
                    rem_d      = '0;
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    if (i_divisor == '0) begin
                        rem_d   = i_dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CW'(DW - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                // Sign correction for truncating division; MIN_NEG / -1 saturates.
                if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    if (ovf_case_q) begin
                        quot_d = MAX_POS;
                        rem_d  = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = neg_quot_q ? (~i_dp_quotient + ONE) : i_dp_quotient;
                        rem_d  = neg_rem_q ? (~i_dp_remainder + ONE) : i_dp_remainder;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered copies of the next state so they align with the state they describe.
        ready_d  = (state_d == S_IDLE);
        init_d   = (state_d == S_LOAD);
        enable_d = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_case_q <= 1'b0;
            init_q     <= 1'b0;
            enable_q   <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ovf_case_q <= ovf_case_d;
            init_q     <= init_d;
            enable_q   <= enable_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_dp_init     = init_q;
    assign o_dp_enable   = enable_q;
    assign o_dp_dividend = dvd_q;
    assign o_dp_divisor  = dvs_q;
    assign o_ready       = ready_q;
    assign o_done        = done_q;
    assign o_quotient    = quot_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural restoring-division datapath.
module tb_div_sequencer;

    localparam int unsigned DW = 16;

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
        logic          ovf;
        int            lat;
        int            en;
        int            init;
        int            acc;
    } exp_t;

    logic          clk;
    logic          rst;
`ifdef DIV_SEQ_ABORT_EN
    logic          i_abort;
`endif
    logic          i_start;
    logic [DW-1:0] i_dividend;
    logic [DW-1:0] i_divisor;
    logic [DW-1:0] i_dp_quotient;
    logic [DW-1:0] i_dp_remainder;
    logic          o_dp_init;
    logic          o_dp_enable;
    logic [DW-1:0] o_dp_dividend;
    logic [DW-1:0] o_dp_divisor;
    logic          o_ready;
    logic          o_done;
    logic [DW-1:0] o_quotient;
    logic [DW-1:0] o_remainder;
    logic          o_div_by_zero;
    logic          o_overflow;

    int   tests;
    int   fails;
    int   cyc;
    int   en_cnt;
    int   init_cnt;
    int   overlap_cnt;
    exp_t sb[$];

    logic [DW-1:0] m_quo;
    logic [DW-1:0] m_rem;
    logic [DW-1:0] m_dvs;

    div_sequencer #(.DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef DIV_SEQ_ABORT_EN
        .i_abort        (i_abort),
`endif
        .i_start        (i_start),
        .i_dividend     (i_dividend),
        .i_divisor      (i_divisor),
        .i_dp_quotient  (i_dp_quotient),
        .i_dp_remainder (i_dp_remainder),
        .o_dp_init      (o_dp_init),
        .o_dp_enable    (o_dp_enable),
        .o_dp_dividend  (o_dp_dividend),
        .o_dp_divisor   (o_dp_divisor),
        .o_ready        (o_ready),
        .o_done         (o_done),
        .o_quotient     (o_quotient),
        .o_remainder    (o_remainder),
        .o_div_by_zero  (o_div_by_zero),
        .o_overflow     (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned restoring divider: one quotient bit per enabled cycle.
    always @(posedge clk) begin : dp_model
        logic [DW:0] nr;
        if (o_dp_init) begin
            m_quo <= o_dp_dividend;
            m_rem <= '0;
            m_dvs <= o_dp_divisor;
        end else if (o_dp_enable) begin
            nr = {m_rem, m_quo[DW-1]};
            if (nr >= {1'b0, m_dvs}) begin
                m_rem <= DW'(nr - {1'b0, m_dvs});
                m_quo <= {m_quo[DW-2:0], 1'b1};
            end else begin
                m_rem <= nr[DW-1:0];
                m_quo <= {m_quo[DW-2:0], 1'b0};
            end
        end
    end
    assign i_dp_quotient  = m_quo;
    assign i_dp_remainder = m_rem;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per o_done and checks result, flags, latency and strobe counts.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (o_dp_init && o_dp_enable) overlap_cnt++;
        if (o_dp_init) init_cnt++;
        if (o_dp_enable) en_cnt++;
        if (o_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(o_done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(o_quotient), 32'(e.q));
                chk("remainder", 32'(o_remainder), 32'(e.r));
                chk("div_by_zero", 32'(o_div_by_zero), 32'(e.dbz));
                chk("overflow", 32'(o_overflow), 32'(e.ovf));
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                chk("enable_cycles", 32'(en_cnt), 32'(e.en));
                chk("init_pulses", 32'(init_cnt), 32'(e.init));
            end
            en_cnt   = 0;
            init_cnt = 0;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    // Issues one request at a negedge; returns at the following negedge with i_start released.
    task automatic do_op(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                         input logic push, input logic [DW-1:0] q, input logic [DW-1:0] r,
                         input logic dbz, input logic ovf);
        exp_t e;
        wait_ready();
        i_start    = 1'b1;
        i_dividend = dvd;
        i_divisor  = dvs;
        if (push) begin
            e.q    = q;
            e.r    = r;
            e.dbz  = dbz;
            e.ovf  = ovf;
            e.lat  = dbz ? 1 : DW + 3;
            e.en   = dbz ? 0 : DW;
            e.init = dbz ? 0 : 1;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        i_start    = 1'b0;
        i_dividend = 16'hDEAD;
        i_divisor  = 16'hBEEF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        en_cnt      = 0;
        init_cnt    = 0;
        overlap_cnt = 0;
        rst         = 1'b0;
        i_start     = 1'b0;
        i_dividend  = '0;
        i_divisor   = '0;
`ifdef DIV_SEQ_ABORT_EN
        i_abort     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_init_enable", 32'({o_dp_init, o_dp_enable}), 32'd0);
        chk("rst_results", 32'({o_quotient, o_remainder}), 32'd0);
        chk("rst_flags", 32'({o_div_by_zero, o_overflow}), 32'd0);
        chk("rst_dp_operands", 32'({o_dp_dividend, o_dp_divisor}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        en_cnt   = 0;
        init_cnt = 0;

        do_op(16'd100,   16'd7,      1'b1, 16'd14,   16'd2,    1'b0, 1'b0);
        do_op(16'hFF9C,  16'd7,      1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'd100,   16'hFFF9,   1'b1, 16'hFFF2, 16'd2,    1'b0, 1'b0);
        do_op(16'd1234,  16'd0,      1'b1, 16'd0,    16'd1234, 1'b1, 1'b0);
        do_op(16'h8000,  16'hFFFF,   1'b1, 16'h7FFF, 16'd0,    1'b0, 1'b1);
        do_op(16'd9,     16'd3,      1'b1, 16'd3,    16'd0,    1'b0, 1'b0);
        do_op(16'hFFF9,  16'hFFFE,   1'b1, 16'd3,    16'hFFFF, 1'b0, 1'b0);
        do_op(16'h8000,  16'd1,      1'b1, 16'h8000, 16'd0,    1'b0, 1'b0);
        do_op(16'hFB2E,  16'd0,      1'b1, 16'd0,    16'hFB2E, 1'b1, 1'b0);

        // A start pulsed mid-run must be ignored entirely.
        do_op(16'd50, 16'd5, 1'b1, 16'd10, 16'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_ready_low", 32'(o_ready), 32'd0);
        i_start    = 1'b1;
        i_dividend = 16'd9;
        i_divisor  = 16'd2;
        @(negedge clk);
        i_start = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        // Reset mid-run: immediate idle, cleared results, no done.
        do_op(16'd100, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_enable", 32'(o_dp_enable), 32'd0);
        chk("midrst_results", 32'({o_quotient, o_remainder}), 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        en_cnt   = 0;
        init_cnt = 0;
        repeat (30) @(negedge clk);
        chk("midrst_idle", 32'(o_ready), 32'd1);

        do_op(16'd0, 16'd5, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0);
        drain();

`ifdef DIV_SEQ_ABORT_EN
        // Abort in the fifth RUN cycle: idle next edge, no done, results unchanged.
        do_op(16'd100, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("abort_in_run", 32'(o_dp_enable), 32'd1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_enable", 32'(o_dp_enable), 32'd0);
        chk("abort_results", 32'({o_quotient, o_remainder}), 32'd0);
        chk("abort_flags", 32'({o_div_by_zero, o_overflow}), 32'd0);
        en_cnt   = 0;
        init_cnt = 0;
        repeat (30) @(negedge clk);
        do_op(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0, 1'b0);
        drain();
`endif

        repeat (5) @(negedge clk);
        chk("init_enable_overlap", 32'(overlap_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Control FSM that sequences the shifted-subtract divider datapath for one signed DW-bit division per request.
- Accepts a start/ready handshake from the system and latches the operands.
- Drives the datapath init/enable strobes for exactly DW iterations, then applies sign correction and reports the result with a done pulse.
- Sits between the system bus logic and the division datapath. The datapath sees only unsigned magnitudes.

Parameters:
- DW, 16, operand/result width in bits. The iteration count equals DW.
- CW, $clog2(DW), width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_start  input  1  request; accepted only when o_ready=1
- i_dividend  input  DW  signed dividend, sampled on accepted start
- i_divisor  input  DW  signed divisor, sampled on accepted start
- i_dp_quotient  input  DW  unsigned quotient magnitude from datapath
- i_dp_remainder  input  DW  unsigned remainder magnitude from datapath
- o_dp_init  output  1  datapath load/init strobe (one cycle)
- o_dp_enable  output  1  datapath iterate enable
- o_dp_dividend  output  DW  |dividend| to datapath
- o_dp_divisor  output  DW  |divisor| to datapath
- o_ready  output  1  idle, can accept i_start
- o_done  output  1  one-cycle pulse, results valid
- o_quotient  output  DW  signed quotient
- o_remainder  output  DW  signed remainder
- o_div_by_zero  output  1  last op had divisor 0
- o_overflow  output  1  last op saturated

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, o_ready=1, all other outputs 0 including the result registers.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: o_ready=1.
  - i_start=1 latches operand magnitudes and signs.
  - Divisor==0: go to DONE, with o_quotient=0, o_remainder=i_dividend, o_div_by_zero=1.
  - Otherwise go to LOAD.
- LOAD (1 cycle): o_dp_init=1, o_dp_enable=0, counter<=DW-1.
- RUN: o_dp_enable=1 each cycle. Counter decrements; after the cycle with counter==0, go to FIX. RUN lasts exactly DW cycles.
- FIX (1 cycle): sample i_dp_quotient and i_dp_remainder.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
- DONE (1 cycle): o_done=1, then go to IDLE.
- Latency: from the accepted-start edge to the o_done cycle is DW+3 cycles for a normal op and 1 cycle for divide-by-zero.
- o_dp_dividend and o_dp_divisor hold stable from LOAD through FIX.
- Magnitude of -2^(DW-1) is 2^(DW-1), which is representable as an unsigned DW-bit value.
- Overflow: -2^(DW-1) / -1 gives o_quotient=2^(DW-1)-1, o_remainder=0, o_overflow=1. The datapath still runs the full sequence.
- Result outputs and flags hold from FIX until the next accepted start. They clear on acceptance.
- i_start while o_ready=0 is ignored, with no queuing. Operand inputs are don't-care outside acceptance.
- o_dp_init and o_dp_enable are never high in the same cycle.
- rst asserted mid-operation returns to IDLE immediately. No o_done is produced.

Optional Feature:
- DIV_SEQ_ABORT_EN defined adds port i_abort (input, 1).
  - i_abort=1 in LOAD, RUN or FIX forces IDLE on the next edge.
  - No o_done is produced. Result registers hold their previous values. o_dp_enable deasserts that edge.
  - i_abort in IDLE or DONE has no effect.
- Undefined: the port is absent and every operation runs to completion.

Test Plan:
- 100 / 7 -> o_done exactly 19 cycles after start (DW=16), q=14, r=2, flags 0; o_dp_enable high for exactly 16 cycles.
- -100 / 7 -> q=-14 (0xFFF2), r=-2 (0xFFFE); 100 / -7 -> q=-14, r=2.
- 1234 / 0 -> o_done 1 cycle after start, q=0, r=1234, o_div_by_zero=1, o_dp_init never asserted.
- -32768 / -1 -> q=32767, r=0, o_overflow=1; a following 9 / 3 clears the flags and gives q=3, r=0.
- i_start pulsed in RUN with other operands -> ignored; the first result is unchanged. rst pulsed in RUN -> o_ready=1 immediately, no o_done.
- With DIV_SEQ_ABORT_EN: i_abort in the 5th RUN cycle -> IDLE next cycle, no o_done, previous results retained.
